clocking_drive_sched: RTL and testbench

//  Synthesisable, multi-channel generalisation of a clocking block. Samples
//  NUM_CH input buses through an IN_SKEW-cycle sample pipeline (input skew).

---
 rtl/clocking_drive_sched.sv | 165 ++++++++++++++++
 tb/tb_clocking_drive_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clocking_drive_sched.sv
// clocking_drive_sched: NUM_CH-channel input-skew sampler plus per-channel ##N drive scheduler.
// Define CLK_SCHED_OVERWRITE_EN to let a new request restart a busy channel instead of stalling.
module clocking_drive_sched #(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 8,
    parameter int IN_SKEW   = 2,
    parameter int MAX_DELAY = 15,
    parameter int DW        = $clog2(MAX_DELAY + 1),
    parameter int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH*WIDTH-1:0] smp_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CHW-1:0]          req_ch,
    input  logic [WIDTH-1:0]        req_data,
    input  logic [DW-1:0]           req_delay,
    output logic [NUM_CH*WIDTH-1:0] drv_data,
    output logic [NUM_CH-1:0]       drv_strobe,
    output logic [NUM_CH-1:0]       busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

    // Each channel's FSM state is kept in state_q so checkers can bind to it directly.
    state_e             state_q [NUM_CH];
    state_e             state_d [NUM_CH];
    logic [DW-1:0]      cnt_q   [NUM_CH];
    logic [DW-1:0]      cnt_d   [NUM_CH];
    logic [WIDTH-1:0]   hold_q  [NUM_CH];
    logic [WIDTH-1:0]   hold_d  [NUM_CH];
    logic [WIDTH-1:0]   drv_q   [NUM_CH];
    logic [WIDTH-1:0]   drv_d   [NUM_CH];
    logic [NUM_CH-1:0]  strobe_q, strobe_d;
    logic [NUM_CH-1:0]  acc_ch;
    logic               ch_ok;
    logic [DW-1:0]      req_delay_sat;

    if (IN_SKEW == 0) begin : g_pass
        assign smp_data = in_data;
    end else begin : g_skew
        logic [NUM_CH*WIDTH-1:0] pipe_q [IN_SKEW];
        logic [NUM_CH*WIDTH-1:0] pipe_d [IN_SKEW];

        always_comb begin
            pipe_d[0] = in_data;
            for (int i = 1; i < IN_SKEW; i++) pipe_d[i] = pipe_q[i-1];
        end

        always_ff @(posedge clock) begin
            for (int i = 0; i < IN_SKEW; i++) begin
                if (reset) pipe_q[i] <= '0;
                else       pipe_q[i] <= pipe_d[i];
            end
        end

        assign smp_data = pipe_q[IN_SKEW-1];
    end

    if (NUM_CH == (1 << CHW)) begin : g_ch_all
        assign ch_ok = 1'b1;
    end else begin : g_ch_lim
        assign ch_ok = (req_ch < CHW'(NUM_CH));
    end

    // The clamp only exists when req_delay can encode values beyond MAX_DELAY.
    if (((1 << DW) - 1) > MAX_DELAY) begin : g_sat
        assign req_delay_sat = (req_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : req_delay;
    end else begin : g_nosat
        assign req_delay_sat = req_delay;
    end

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready depends only on req_ch and current state, never on req_valid.
`ifdef CLK_SCHED_OVERWRITE_EN
    assign req_ready = ch_ok;
`else
    logic sel_busy;
    always_comb begin
        sel_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_ch == CHW'(c)) sel_busy = (state_q[c] == ST_WAIT);
        end
    end
    assign req_ready = ch_ok && !sel_busy;
`endif

    always_comb begin
        acc_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_ch[c] = req_valid && req_ready && (req_ch == CHW'(c));
        end
    end

    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            hold_d[c]  = hold_q[c];
            drv_d[c]   = drv_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (acc_ch[c]) begin
                        state_d[c] = ST_WAIT;
                        cnt_d[c]   = req_delay_sat;
                        hold_d[c]  = req_data;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q[c] == '0) begin
                        drv_d[c]    = hold_q[c];
                        strobe_d[c] = 1'b1;
                        state_d[c]  = ST_IDLE;
                    end else begin
                        cnt_d[c] = cnt_q[c] - DW'(1);
                    end
`ifdef CLK_SCHED_OVERWRITE_EN
                    // A new request restarts the wait; on the apply edge the old value still lands.
                    if (acc_ch[c]) begin
                        state_d[c] = ST_WAIT;
                        cnt_d[c]   = req_delay_sat;
                        hold_d[c]  = req_data;
                    end
`endif
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                hold_q[c]  <= '0;
                drv_q[c]   <= '0;
            end
            strobe_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                hold_q[c]  <= hold_d[c];
                drv_q[c]   <= drv_d[c];
            end
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        drv_data = '0;
        busy     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drv_data[c*WIDTH +: WIDTH] = drv_q[c];
            busy[c] = (state_q[c] == ST_WAIT);
        end
    end

    assign drv_strobe = strobe_q;

endmodule

// File: tb/tb_clocking_drive_sched.sv
// Bench for clocking_drive_sched: default instance (2 ch, skew 2, max 15) and a
// 3-channel instance (skew 0, max 10) exercising channel-range and delay clamping.
module tb_clocking_drive_sched;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] a_in = '0, a_smp, a_drv;
    logic        a_req_valid = 1'b0, a_req_ready;
    logic [0:0]  a_req_ch = '0;
    logic [7:0]  a_req_data = '0;
    logic [3:0]  a_req_delay = '0;
    logic [1:0]  a_strobe, a_busy;

    logic [23:0] b_in = '0, b_smp, b_drv;
    logic        b_req_valid = 1'b0, b_req_ready;
    logic [1:0]  b_req_ch = '0;
    logic [7:0]  b_req_data = '0;
    logic [3:0]  b_req_delay = '0;
    logic [2:0]  b_strobe, b_busy;

    clocking_drive_sched u_dut (
        .clock(clock), .reset(reset), .in_data(a_in), .smp_data(a_smp),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_ch(a_req_ch),
        .req_data(a_req_data), .req_delay(a_req_delay), .drv_data(a_drv),
        .drv_strobe(a_strobe), .busy(a_busy)
    );

    clocking_drive_sched #(.NUM_CH(3), .WIDTH(8), .IN_SKEW(0), .MAX_DELAY(10)) u_dut3 (
        .clock(clock), .reset(reset), .in_data(b_in), .smp_data(b_smp),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_ch(b_req_ch),
        .req_data(b_req_data), .req_delay(b_req_delay), .drv_data(b_drv),
        .drv_strobe(b_strobe), .busy(b_busy)
    );

    // entry = {dut[26], apply_cycle[25:10], ch[9:8], data[7:0]}
    localparam int W = 27;
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic push_exp(input int d, input int c, input int at, input logic [7:0] data);
        exp_q.push_back({1'(d), 16'(at), 2'(c), data});
    endtask

    task automatic set_req(input int d, input bit v, input int c, input logic [7:0] data, input int dly);
        if (d == 0) begin
            a_req_valid = v; a_req_ch = 1'(c); a_req_data = data; a_req_delay = 4'(dly);
        end else begin
            b_req_valid = v; b_req_ch = 2'(c); b_req_data = data; b_req_delay = 4'(dly);
        end
    endtask

    task automatic monitor_loop();
        logic [15:0] prev_a = '0;
        logic [23:0] prev_b = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < ((d == 0) ? 2 : 3); c++) begin
                        logic stb;
                        logic [7:0] got, prev;
                        logic [W-1:0] e;
                        int idx;
                        stb  = (d == 0) ? a_strobe[c] : b_strobe[c];
                        got  = (d == 0) ? a_drv[c*8 +: 8] : b_drv[c*8 +: 8];
                        prev = (d == 0) ? prev_a[c*8 +: 8] : prev_b[c*8 +: 8];
                        total++;
                        if (stb) begin
                            idx = -1;
                            for (int i = 0; i < exp_q.size(); i++)
                                if (idx < 0 && int'(exp_q[i][26]) == d && int'(exp_q[i][9:8]) == c) idx = i;
                            if (idx < 0) begin
                                bad++;
                                $display("FAIL drive_unexpected dut=%0d ch=%0d got=%h at cycle %0d, required no drive",
                                         d, c, got, cyc);
                            end else begin
                                e = exp_q[idx];
                                exp_q.delete(idx);
                                if (got !== e[7:0] || cyc[15:0] !== e[25:10]) begin
                                    bad++;
                                    $display("FAIL drive dut=%0d ch=%0d got=%h@%0d required=%h@%0d",
                                             d, c, got, cyc, e[7:0], e[25:10]);
                                end
                            end
                        end else if (got !== prev) begin
                            bad++;
                            $display("FAIL drv_hold dut=%0d ch=%0d got=%h required=%h (no strobe)", d, c, got, prev);
                        end
                    end
                end
            end
            prev_a = a_drv;
            prev_b = b_drv;
        end
    endtask

    task automatic issue(input int d, input int c, input logic [7:0] data, input int dly,
                         input bit exp_it, output int k);
        int tries;
        int eff;
        int maxd;
        tries = 0;
        maxd = (d == 0) ? 15 : 10;
        @(negedge clock);
        set_req(d, 1'b1, c, data, dly);
        #1;
        while (!((d == 0) ? a_req_ready : b_req_ready) && tries < 50) begin
            @(negedge clock);
            #1;
            tries++;
        end
        total++;
        if (tries >= 50) begin
            bad++;
            $display("FAIL issue_timeout dut=%0d ch=%0d req_ready=0 for %0d cycles, required 1", d, c, tries);
            set_req(d, 1'b0, 0, 8'h00, 0);
            k = -1;
            return;
        end
        @(posedge clock);
        #1;
        k = cyc;
        set_req(d, 1'b0, 0, 8'h00, 0);
        eff = (dly > maxd) ? maxd : dly;
        if (exp_it) push_exp(d, c, k + 1 + eff, data);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (a_drv !== 16'h0)   begin bad++; $display("FAIL rst_drv got=%h required=0000", a_drv); end
        total++; if (a_strobe !== 2'b0) begin bad++; $display("FAIL rst_strobe got=%b required=00", a_strobe); end
        total++; if (a_busy !== 2'b0)   begin bad++; $display("FAIL rst_busy got=%b required=00", a_busy); end
        total++; if (a_smp !== 16'h0)   begin bad++; $display("FAIL rst_smp got=%h required=0000", a_smp); end
        total++; if (b_drv !== 24'h0)   begin bad++; $display("FAIL rst_drv3 got=%h required=000000", b_drv); end
        reset = 1'b0;
        issue(0, 1, 8'h5A, 0, 1'b1, k);
        wait_drain();
        issue(0, 0, 8'h77, 10, 1'b0, k);
        repeat (3) @(negedge clock);
        total++; if (a_busy !== 2'b01) begin bad++; $display("FAIL wait_busy got=%b required=01", a_busy); end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (a_drv !== 16'h0)   begin bad++; $display("FAIL midrst_drv got=%h required=0000", a_drv); end
        total++; if (a_busy !== 2'b0)   begin bad++; $display("FAIL midrst_busy got=%b required=00", a_busy); end
        total++; if (a_strobe !== 2'b0) begin bad++; $display("FAIL midrst_strobe got=%b required=00", a_strobe); end
        reset = 1'b0;
        repeat (15) @(negedge clock);
        total++; if (a_busy !== 2'b0)   begin bad++; $display("FAIL postrst_busy got=%b required=00", a_busy); end
    endtask

    task automatic test_skew();
        logic [23:0] r;
        @(negedge clock);
        a_in = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        a_in = 16'h3CA5;
        @(negedge clock);
        @(negedge clock);
        total++; if (a_smp !== 16'h0000) begin bad++; $display("FAIL skew_early got=%h required=0000", a_smp); end
        @(negedge clock);
        total++; if (a_smp !== 16'h3CA5) begin bad++; $display("FAIL skew_arrive got=%h required=3ca5", a_smp); end
        for (int i = 0; i < 3; i++) begin
            r = 24'($urandom);
            b_in = r;
            #1;
            total++; if (b_smp !== r) begin bad++; $display("FAIL skew0_pass got=%h required=%h", b_smp, r); end
        end
    endtask

    task automatic test_delay();
        int k1, k2;
        issue(0, 1, 8'h3C, 0, 1'b1, k1);
        wait_drain();
        issue(0, 1, 8'hC3, 5, 1'b1, k1);
        wait_drain();
        issue(0, 0, 8'h21, 3, 1'b1, k1);
        issue(0, 0, 8'h12, 0, 1'b1, k2);
        total++; if (k2 - k1 !== 5) begin bad++; $display("FAIL throughput got=%0d required=5", k2 - k1); end
        for (int i = 0; i < 10; i++) begin
            issue(0, $urandom_range(0, 1), 8'($urandom_range(0, 255)), $urandom_range(0, 6), 1'b1, k1);
        end
        wait_drain();
    endtask

    task automatic test_back_pressure();
        int k, k2, n;
        issue(0, 0, 8'h44, 4, 1'b1, k);
        @(negedge clock);
        set_req(0, 1'b1, 0, 8'h55, 0);
        #1;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL bp_busy_ready got=%b required=0", a_req_ready); end
        set_req(0, 1'b1, 1, 8'h66, 1);
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b required=1", a_req_ready); end
        @(posedge clock);
        #1;
        push_exp(0, 1, cyc + 2, 8'h66);
        set_req(0, 1'b0, 0, 8'h00, 0);
        @(negedge clock);
        set_req(0, 1'b1, 0, 8'h55, 0);
        #1;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL bp_stall got=%0d cycles required=4", n); end
        @(posedge clock);
        #1;
        k2 = cyc;
        push_exp(0, 0, k2 + 1, 8'h55);
        set_req(0, 1'b0, 0, 8'h00, 0);
        total++; if (k2 !== k + 6) begin bad++; $display("FAIL bp_reaccept got=%0d required=%0d", k2, k + 6); end
        wait_drain();
    endtask

    task automatic test_sat_range();
        int k;
        issue(0, 0, 8'hE1, 15, 1'b1, k);
        wait_drain();
        issue(1, 2, 8'h9E, 15, 1'b1, k);
        wait_drain();
        issue(1, 0, 8'h0F, 10, 1'b1, k);
        issue(1, 1, 8'hF0, 2, 1'b1, k);
        wait_drain();
        @(negedge clock);
        set_req(1, 1'b1, 3, 8'hBB, 0);
        #1;
        total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL range_ready got=%b required=0", b_req_ready); end
        @(posedge clock);
        #1;
        set_req(1, 1'b0, 0, 8'h00, 0);
        @(negedge clock);
        total++; if (b_busy !== 3'b000) begin bad++; $display("FAIL range_busy got=%b required=000", b_busy); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_simul();
        int k1, k2;
        issue(0, 0, 8'hAA, 3, 1'b1, k1);
        issue(0, 1, 8'h55, 2, 1'b1, k2);
        total++; if (k2 !== k1 + 1) begin bad++; $display("FAIL simul_accept got=%0d required=%0d", k2, k1 + 1); end
        wait_drain();
    endtask

`ifdef CLK_SCHED_OVERWRITE_EN
    task automatic test_overwrite();
        int k1, k2;
        issue(0, 0, 8'h11, 8, 1'b0, k1);
        repeat (2) @(posedge clock);
        issue(0, 0, 8'h22, 2, 1'b1, k2);
        total++; if (k2 !== k1 + 3) begin bad++; $display("FAIL ow_accept got=%0d required=%0d", k2, k1 + 3); end
        wait_drain();
        repeat (10) @(negedge clock);
    endtask
`endif

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_skew();
        test_delay();
        test_back_pressure();
        test_sat_range();
        test_simul();
`ifdef CLK_SCHED_OVERWRITE_EN
        test_overwrite();
`endif
        wait_drain();
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
